// File: rtl/vmx_mm_scratchpad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vmx_mm_pkg
// Brief    : Shared constants for the VMX matrix-multiply scratchpad.
// Revision : 1.0 - initial release
// ============================================================================
package vmx_mm_pkg;

    localparam int RD_W    = 64;
    localparam int WR_W    = 128;
    localparam int HOST_W  = 32;
    localparam int STALL_W = 16;

    localparam logic [0:0] H_IDLE = 1'b0;
    localparam logic [0:0] H_RESP = 1'b1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_EXPO  = 3'd4;

    localparam int REG_STATUS = 0;
    localparam int REG_STALL  = 1;

endpackage
`default_nettype wire

// File: rtl/vmx_mm_scratchpad_if.sv
`default_nettype none
// ============================================================================
// Module   : vmx_mm_scratchpad_if
// Brief    : Host valid/ready request/response port of the scratchpad.
// Revision : 1.0 - initial release
// ============================================================================
interface vmx_mm_scratchpad_if #(
    parameter int ADDR_W = 8,
    parameter int HOST_W = 32
);
    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_we;
    logic [ADDR_W+1:0] host_req_addr;
    logic [HOST_W-1:0] host_req_wdata;
    logic              host_rsp_valid;
    logic              host_rsp_ready;
    logic [HOST_W-1:0] host_rsp_rdata;

    modport master (
        output host_req_valid, host_req_we, host_req_addr, host_req_wdata, host_rsp_ready,
        input  host_req_ready, host_rsp_valid, host_rsp_rdata
    );

    modport slave (
        input  host_req_valid, host_req_we, host_req_addr, host_req_wdata, host_rsp_ready,
        output host_req_ready, host_rsp_valid, host_rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/vmx_mm_scratchpad_mem.sv
`default_nettype none
// ============================================================================
// Module   : vmx_spad_mem
// Brief    : 64-bit word array; combinational accelerator read, two-word
//            accelerator write, half-word host read/write.
// Revision : 1.0 - initial release
// ============================================================================
module vmx_spad_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int RD_W   = 64,
    parameter int WR_W   = 128,
    parameter int HOST_W = 32
) (
    input  wire logic              clk,
    input  wire logic [ADDR_W-1:0] acc_addr,
    input  wire logic              acc_wr_en,
    input  wire logic [WR_W-1:0]   acc_wdata,
    output logic      [RD_W-1:0]   acc_rdata,
    input  wire logic [ADDR_W-1:0] host_addr,
    input  wire logic              host_half,
    input  wire logic              host_wr_en,
    input  wire logic [HOST_W-1:0] host_wdata,
    output logic      [HOST_W-1:0] host_rdata
);
    logic [RD_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0] w_acc_addr_hi;

    // DEPTH is a power of two, so natural overflow gives the wrap to word 0
    assign w_acc_addr_hi = acc_addr + 1'b1;

    // Accelerator writes are issued last so they override a host half-write
    // to the same word on the same edge.
    always_ff @(posedge clk) begin
        if (host_wr_en) begin
            if (host_half) begin
                r_mem[host_addr][RD_W-1:HOST_W] <= host_wdata;
            end else begin
                r_mem[host_addr][HOST_W-1:0] <= host_wdata;
            end
        end
        if (acc_wr_en) begin
            r_mem[acc_addr]      <= acc_wdata[RD_W-1:0];
            r_mem[w_acc_addr_hi] <= acc_wdata[WR_W-1:RD_W];
        end
    end

    assign acc_rdata  = r_mem[acc_addr];
    assign host_rdata = host_half ? r_mem[host_addr][RD_W-1:HOST_W]
                                  : r_mem[host_addr][HOST_W-1:0];
endmodule
`default_nettype wire

// File: rtl/vmx_mm_scratchpad.sv
`default_nettype none
// ============================================================================
// Module   : vmx_mm_scratchpad
// Brief    : VMX matmul scratchpad: accelerator port plus a stallable host
//            port. Optional stall counter enabled by VMX_SPAD_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vmx_mm_scratchpad #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int RD_W   = vmx_mm_pkg::RD_W,
    parameter int WR_W   = vmx_mm_pkg::WR_W,
    parameter int HOST_W = vmx_mm_pkg::HOST_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [ADDR_W-1:0] acc_addr,
    input  wire logic              acc_wr_en,
    input  wire logic [WR_W-1:0]   acc_wdata,
    output logic      [RD_W-1:0]   acc_rdata,
    input  wire logic [2:0]        acc_flag,
    vmx_mm_scratchpad_if.slave     host
);
    import vmx_mm_pkg::*;

    logic [0:0]          r_state;
    logic                r_rsp_valid;
    logic [HOST_W-1:0]   r_rsp_rdata;

    logic                w_acc_active;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_reg_sel;
    logic [ADDR_W:0]     w_reg_off;
    logic [ADDR_W-1:0]   w_word;
    logic                w_half;
    logic                w_mem_wr;
    logic [HOST_W-1:0]   w_mem_rdata;
    logic [HOST_W-1:0]   w_reg_rdata;
    logic [HOST_W-1:0]   w_rd_data;
    logic [STALL_W-1:0]  w_stall_cnt;

    assign w_acc_active = (acc_flag != S_IDLE);
    // Gated by rst so the port advertises not-ready while held in reset
    assign w_req_ready  = (r_state == H_IDLE) && !w_acc_active && !rst;
    assign w_accept     = host.host_req_valid && w_req_ready;
    assign w_reg_sel    = host.host_req_addr[ADDR_W+1];
    assign w_reg_off    = host.host_req_addr[ADDR_W:0];
    assign w_word       = host.host_req_addr[ADDR_W:1];
    assign w_half       = host.host_req_addr[0];
    assign w_mem_wr     = w_accept && host.host_req_we && !w_reg_sel;

    vmx_spad_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_W   (RD_W),
        .WR_W   (WR_W),
        .HOST_W (HOST_W)
    ) u_mem (
        .clk        (clk),
        .acc_addr   (acc_addr),
        .acc_wr_en  (acc_wr_en),
        .acc_wdata  (acc_wdata),
        .acc_rdata  (acc_rdata),
        .host_addr  (w_word),
        .host_half  (w_half),
        .host_wr_en (w_mem_wr),
        .host_wdata (host.host_req_wdata),
        .host_rdata (w_mem_rdata)
    );

`ifdef VMX_SPAD_STALL_CNT_EN
    logic                r_stall_cnt_q;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic                w_stall_clr;
    logic                w_stall_inc;

    assign w_stall_clr = w_accept && host.host_req_we && w_reg_sel
                         && (w_reg_off == (ADDR_W+1)'(REG_STALL));
    assign w_stall_inc = host.host_req_valid && w_acc_active && (r_state == H_IDLE)
                         && (r_stall_cnt != '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign w_stall_cnt = r_stall_cnt;
`else
    assign w_stall_cnt = '0;
`endif

    always_comb begin
        w_reg_rdata = '0;
        if (w_reg_off == (ADDR_W+1)'(REG_STATUS)) begin
            w_reg_rdata = {{(HOST_W-3){1'b0}}, acc_flag};
        end else if (w_reg_off == (ADDR_W+1)'(REG_STALL)) begin
            w_reg_rdata = HOST_W'(w_stall_cnt);
        end
    end

    assign w_rd_data = w_reg_sel ? w_reg_rdata : w_mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= H_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                H_IDLE: begin
                    if (w_accept) begin
                        r_state     <= H_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= host.host_req_we ? '0 : w_rd_data;
                    end
                end
                H_RESP: begin
                    if (host.host_rsp_ready) begin
                        r_state     <= H_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= H_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign host.host_req_ready = w_req_ready;
    assign host.host_rsp_valid = r_rsp_valid;
    assign host.host_rsp_rdata = r_rsp_rdata;
endmodule
`default_nettype wire

// File: tb/tb_vmx_mm_scratchpad.sv
`default_nettype none
// ============================================================================
// Module   : tb_vmx_mm_scratchpad
// Brief    : Self-checking bench for vmx_mm_scratchpad (vector table plus
//            scoreboard queue of expected host responses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vmx_mm_scratchpad;

    logic         clk;
    logic         rst;
    logic [7:0]   acc_addr;
    logic         acc_wr_en;
    logic [127:0] acc_wdata;
    logic [63:0]  acc_rdata;
    logic [2:0]   acc_flag;

    vmx_mm_scratchpad_if #(.ADDR_W(8), .HOST_W(32)) hif ();

    vmx_mm_scratchpad dut (
        .clk       (clk),
        .rst       (rst),
        .acc_addr  (acc_addr),
        .acc_wr_en (acc_wr_en),
        .acc_wdata (acc_wdata),
        .acc_rdata (acc_rdata),
        .acc_flag  (acc_flag),
        .host      (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef VMX_SPAD_STALL_CNT_EN
    localparam logic [31:0] STALL_EXP = 32'd5;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] exp_q [$];
    int          checks;
    int          failures;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic collect_rsp(input string name);
        int          n;
        logic [31:0] e;
        n = 0;
        while (!hif.host_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!hif.host_rsp_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: response timeout got valid=0 expected valid=1", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        check(name, 64'(hif.host_rsp_rdata), 64'(e));
        hif.host_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        hif.host_rsp_ready = 1'b0;
    endtask

    task automatic host_txn(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp, input string name);
        int n;
        hif.host_req_valid = 1'b1;
        hif.host_req_we    = we;
        hif.host_req_addr  = addr;
        hif.host_req_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!hif.host_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!hif.host_req_ready) begin
            checks++;
            failures++;
            $display("FAIL %s: request timeout got ready=0 expected ready=1", name);
            hif.host_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        hif.host_req_valid = 1'b0;
        hif.host_req_we    = 1'b0;
        exp_q.push_back(exp);
        @(negedge clk);
        check({name, "_lat"}, 64'(hif.host_rsp_valid), 64'd1);
        collect_rsp(name);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        acc_addr  = '0;
        acc_wr_en = 1'b0;
        acc_wdata = '0;
        acc_flag  = 3'd0;
        hif.host_req_valid = 1'b0;
        hif.host_req_we    = 1'b0;
        hif.host_req_addr  = '0;
        hif.host_req_wdata = '0;
        hif.host_rsp_ready = 1'b0;

        vecs[0] = '{1'b1, 10'h010, 32'h11111111, 32'h0,        "wr_lo"};
        vecs[1] = '{1'b1, 10'h011, 32'h22222222, 32'h0,        "wr_hi"};
        vecs[2] = '{1'b0, 10'h010, 32'h0,        32'h11111111, "rd_lo"};
        vecs[3] = '{1'b0, 10'h011, 32'h0,        32'h22222222, "rd_hi"};
        vecs[4] = '{1'b1, 10'h013, 32'hA5A5A5A5, 32'h0,        "wr_w9"};
        vecs[5] = '{1'b0, 10'h013, 32'h0,        32'hA5A5A5A5, "raw_w9"};
        vecs[6] = '{1'b0, 10'h200, 32'h0,        32'h0,        "rd_status"};
        vecs[7] = '{1'b1, 10'h207, 32'hFFFFFFFF, 32'h0,        "wr_reg7"};
        vecs[8] = '{1'b0, 10'h207, 32'h0,        32'h0,        "rd_reg7"};
        vecs[9] = '{1'b0, 10'h010, 32'h0,        32'h11111111, "rd_lo2"};

        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(hif.host_req_ready), 64'd0);
        check("rst_rsp_valid", 64'(hif.host_rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(hif.host_rsp_rdata), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            host_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].name);
        end

        acc_addr = 8'h08;
        #1;
        check("acc_rd_w8", acc_rdata, 64'h2222222211111111);

        // two-word accelerator write wrapping past the last word
        acc_addr  = 8'hFF;
        acc_wdata = {64'hB, 64'hA};
        acc_wr_en = 1'b1;
        @(posedge clk);
        #1;
        acc_wr_en = 1'b0;
        check("acc_rd_wff", acc_rdata, 64'hA);
        host_txn(1'b0, 10'h1FE, 32'h0, 32'hA, "wrap_ff_lo");
        host_txn(1'b0, 10'h1FF, 32'h0, 32'h0, "wrap_ff_hi");
        host_txn(1'b0, 10'h000, 32'h0, 32'hB, "wrap_00_lo");
        host_txn(1'b0, 10'h001, 32'h0, 32'h0, "wrap_00_hi");

        // accelerator busy: host held off for 5 cycles
        acc_flag           = 3'd3;
        hif.host_req_valid = 1'b1;
        hif.host_req_we    = 1'b0;
        hif.host_req_addr  = 10'h200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("busy_ready", 64'(hif.host_req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        acc_flag = 3'd0;
        @(negedge clk);
        check("unbusy_ready", 64'(hif.host_req_ready), 64'd1);
        @(posedge clk);
        #1;
        hif.host_req_valid = 1'b0;
        exp_q.push_back(32'h0);
        @(negedge clk);
        collect_rsp("status_after_busy");
        host_txn(1'b0, 10'h201, 32'h0, STALL_EXP, "stall_cnt");
        host_txn(1'b1, 10'h201, 32'h0, 32'h0,     "stall_clr");
        host_txn(1'b0, 10'h201, 32'h0, 32'h0,     "stall_cnt_clr");

        // response held off while the accelerator becomes busy
        hif.host_req_valid = 1'b1;
        hif.host_req_we    = 1'b0;
        hif.host_req_addr  = 10'h011;
        @(negedge clk);
        check("hold_ready", 64'(hif.host_req_ready), 64'd1);
        @(posedge clk);
        #1;
        hif.host_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(hif.host_rsp_valid), 64'd1);
            check("hold_rdata", 64'(hif.host_rsp_rdata), 64'h22222222);
            if (i == 0) acc_flag = 3'd1;
        end
        exp_q.push_back(32'h22222222);
        collect_rsp("hold_rsp");
        @(negedge clk);
        check("hold_done_valid", 64'(hif.host_rsp_valid), 64'd0);
        check("hold_busy_ready", 64'(hif.host_req_ready), 64'd0);
        @(posedge clk);
        #1;
        acc_flag = 3'd0;

        // accelerator and host write the same word on one edge
        acc_addr           = 8'h20;
        acc_wdata          = {64'h0123456789ABCDEF, 64'hCAFEF00D12345678};
        acc_wr_en          = 1'b1;
        hif.host_req_valid = 1'b1;
        hif.host_req_we    = 1'b1;
        hif.host_req_addr  = 10'h040;
        hif.host_req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("collide_ready", 64'(hif.host_req_ready), 64'd1);
        @(posedge clk);
        #1;
        acc_wr_en          = 1'b0;
        hif.host_req_valid = 1'b0;
        hif.host_req_we    = 1'b0;
        exp_q.push_back(32'h0);
        @(negedge clk);
        collect_rsp("collide_ack");
        host_txn(1'b0, 10'h040, 32'h0, 32'h12345678, "collide_lo");
        host_txn(1'b0, 10'h041, 32'h0, 32'hCAFEF00D, "collide_hi");
        host_txn(1'b0, 10'h042, 32'h0, 32'h89ABCDEF, "collide_next");

        // reset while a response is pending
        hif.host_req_valid = 1'b1;
        hif.host_req_we    = 1'b0;
        hif.host_req_addr  = 10'h010;
        @(posedge clk);
        #1;
        hif.host_req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 64'(hif.host_rsp_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(hif.host_rsp_valid), 64'd0);
        check("mid_rst_rdata", 64'(hif.host_rsp_rdata), 64'd0);
        check("mid_rst_ready", 64'(hif.host_req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        host_txn(1'b0, 10'h010, 32'h0, 32'h11111111, "post_rst_rd");
        acc_addr = 8'h08;
        #1;
        check("post_rst_acc", acc_rdata, 64'h2222222211111111);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
